// File: rtl/rv_scoreboard_hazard_unit.sv
// rv_scoreboard_hazard_unit: in-order scoreboard tracking in-flight rd writes for RAW/WAW stalls, commit and flush rollback.
// Define RV_SCOREBOARD_PERF_EN to add the stall_cycles and flushed_entries counters.
module rv_scoreboard_hazard_unit #(
    parameter int DEPTH    = 4,
    parameter int NUM_REGS = 32,
    parameter int REG_W    = $clog2(NUM_REGS),
    parameter int NUM_SRC  = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     issue_valid,
    input  logic [REG_W-1:0]         issue_rd,
    input  logic [NUM_SRC*REG_W-1:0] issue_rs,
    output logic                     issue_ready,
    input  logic                     commit,
    input  logic                     wb,
    input  logic                     flush,
    output logic                     stall_raw,
    output logic                     stall_waw,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH+1)-1:0] inflight,
    output logic                     proto_err
`ifdef RV_SCOREBOARD_PERF_EN
   ,output logic [31:0]              stall_cycles,
    output logic [31:0]              flushed_entries
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] valid, cmtd;
    logic [REG_W-1:0] rd_q [DEPTH];
    logic [PW-1:0]    head, cmt, tail, cmt_nx;
    logic [CW-1:0]    count, ncmt, ncmt_nx;
    logic             commit_ok, wb_ok, push;

    always_comb begin
        stall_raw = 1'b0;
        stall_waw = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
            if (valid[e] && rd_q[e] != '0) begin
                for (int s = 0; s < NUM_SRC; s++)
                    if (issue_rs[s*REG_W +: REG_W] != '0 && issue_rs[s*REG_W +: REG_W] == rd_q[e])
                        stall_raw = 1'b1;
                if (issue_rd != '0 && issue_rd == rd_q[e])
                    stall_waw = 1'b1;
            end
        end
    end

    assign full        = count == CW'(DEPTH);
    assign empty       = count == '0;
    assign inflight    = count;
    assign issue_ready = !full && !stall_raw && !stall_waw && !flush;
    // cmt only ever rests on an uncommitted entry or on an empty/committed slot
    assign commit_ok   = commit && valid[cmt] && !cmtd[cmt];
    assign wb_ok       = wb && valid[head] && cmtd[head];
    assign push        = issue_valid && issue_ready && issue_rd != '0;
    assign cmt_nx      = commit_ok ? cmt + PW'(1) : cmt;
    assign ncmt_nx     = ncmt + CW'(commit_ok) - CW'(wb_ok);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid     <= '0;
            cmtd      <= '0;
            head      <= '0;
            cmt       <= '0;
            tail      <= '0;
            count     <= '0;
            ncmt      <= '0;
            proto_err <= 1'b0;
        end else begin
            if (commit_ok)
                cmtd[cmt] <= 1'b1;
            cmt <= cmt_nx;
            if (wb_ok) begin
                valid[head] <= 1'b0;
                head        <= head + PW'(1);
            end
            if (flush) begin
                for (int e = 0; e < DEPTH; e++)
                    if (valid[e] && !cmtd[e] && !(commit_ok && PW'(e) == cmt))
                        valid[e] <= 1'b0;
                tail <= cmt_nx;
            end else if (push) begin
                valid[tail] <= 1'b1;
                cmtd[tail]  <= 1'b0;
                tail        <= tail + PW'(1);
            end
            count <= flush ? ncmt_nx : count - CW'(wb_ok) + CW'(push);
            ncmt  <= ncmt_nx;
            if ((commit && !commit_ok) || (wb && !wb_ok))
                proto_err <= 1'b1;
        end
    end

    always_ff @(posedge CLK)
        if (push)
            rd_q[tail] <= issue_rd;

`ifdef RV_SCOREBOARD_PERF_EN
    logic [CW-1:0] dropped;
    logic [32:0]   fl_sum;
    assign dropped = count - CW'(wb_ok) - ncmt_nx;
    assign fl_sum  = {1'b0, flushed_entries} + 33'(dropped);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cycles    <= '0;
            flushed_entries <= '0;
        end else begin
            if (issue_valid && !issue_ready && stall_cycles != '1)
                stall_cycles <= stall_cycles + 32'd1;
            if (flush)
                flushed_entries <= fl_sum[32] ? '1 : fl_sum[31:0];
        end
    end
`endif
endmodule

// File: tb/tb_rv_scoreboard_hazard_unit.sv
// tb_rv_scoreboard_hazard_unit: queue-based reference model checked every cycle plus directed literal checks.
module tb_rv_scoreboard_hazard_unit;
    localparam int DEPTH = 4;
    localparam int RW    = 5;

    typedef struct {
        logic [RW-1:0] rd;
        bit            c;
    } ent_t;

    logic          clk = 1'b0, rst = 1'b1;
    logic          issue_valid = 1'b0, commit = 1'b0, wb = 1'b0, flush = 1'b0;
    logic [RW-1:0] issue_rd = '0;
    logic [2*RW-1:0] issue_rs = '0;
    logic          issue_ready, stall_raw, stall_waw, full, empty, proto_err;
    logic [2:0]    inflight;
`ifdef RV_SCOREBOARD_PERF_EN
    logic [31:0]   stall_cycles, flushed_entries;
`endif

    int   vecs = 0, errs = 0;
    ent_t q[$];
    bit   merr = 0;
    int   m_stall = 0, m_fl = 0, k;
    bit   m_wbok, m_rdy;

    rv_scoreboard_hazard_unit #(.DEPTH(DEPTH), .NUM_REGS(32), .NUM_SRC(2)) dut (
        .CLK(clk), .RST(rst), .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rs(issue_rs),
        .issue_ready(issue_ready), .commit(commit), .wb(wb), .flush(flush),
        .stall_raw(stall_raw), .stall_waw(stall_waw), .full(full), .empty(empty),
        .inflight(inflight), .proto_err(proto_err)
`ifdef RV_SCOREBOARD_PERF_EN
       ,.stall_cycles(stall_cycles), .flushed_entries(flushed_entries)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        vecs++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    function automatic bit m_raw();
        logic [RW-1:0] r1 = issue_rs[RW-1:0];
        logic [RW-1:0] r2 = issue_rs[2*RW-1:RW];
        foreach (q[i])
            if ((r1 != 0 && r1 == q[i].rd) || (r2 != 0 && r2 == q[i].rd)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_waw();
        foreach (q[i])
            if (issue_rd != 0 && issue_rd == q[i].rd) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_ready();
        return q.size() < DEPTH && !m_raw() && !m_waw() && !flush;
    endfunction

    // Reference: queue of {rd, committed}; commit marks the oldest uncommitted, wb pops a committed head
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            merr    = 0;
            m_stall = 0;
            m_fl    = 0;
        end else begin
            m_rdy  = m_ready();
            m_wbok = q.size() > 0 && q[0].c;
            if (issue_valid && !m_rdy) m_stall++;
            if (commit) begin
                k = -1;
                foreach (q[i]) if (!q[i].c && k < 0) k = i;
                if (k < 0) merr = 1; else q[k].c = 1;
            end
            if (wb) begin
                if (m_wbok) void'(q.pop_front()); else merr = 1;
            end
            if (flush)
                while (q.size() > 0 && !q[q.size()-1].c) begin
                    void'(q.pop_back());
                    m_fl++;
                end
            if (issue_valid && m_rdy && issue_rd != 0)
                q.push_back('{issue_rd, 1'b0});
        end
    end

    always @(negedge clk) begin
        chk("issue_ready", 32'(issue_ready), 32'(m_ready()));
        chk("stall_raw", 32'(stall_raw), 32'(m_raw()));
        chk("stall_waw", 32'(stall_waw), 32'(m_waw()));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("inflight", 32'(inflight), 32'(q.size()));
        chk("proto_err", 32'(proto_err), 32'(merr));
`ifdef RV_SCOREBOARD_PERF_EN
        chk("stall_cycles", stall_cycles, 32'(m_stall));
        chk("flushed_entries", flushed_entries, 32'(m_fl));
`endif
    end

    task automatic drive(input bit v, input int rd, input int rs1, input int rs2,
                         input bit c, input bit w, input bit f);
        @(posedge clk);
        #1;
        issue_valid = v;
        issue_rd    = RW'(rd);
        issue_rs    = {RW'(rs2), RW'(rs1)};
        commit      = c;
        wb          = w;
        flush       = f;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle();
        chk("rst_empty", 32'(empty), 1);
        chk("rst_inflight", 32'(inflight), 0);
        chk("rst_ready", 32'(issue_ready), 1);
        drive(1, 5, 0, 0, 0, 0, 0);
        chk("push5_ready", 32'(issue_ready), 1);
        drive(1, 6, 5, 0, 0, 0, 0);
        chk("raw5", 32'(stall_raw), 1);
        chk("raw5_ready", 32'(issue_ready), 0);
        chk("raw5_inflight", 32'(inflight), 1);
        chk("raw5_empty", 32'(empty), 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(1, 6, 5, 0, 0, 1, 0);
        chk("wb_no_bypass", 32'(stall_raw), 1);
        drive(1, 6, 5, 0, 0, 0, 0);
        chk("wb_cleared", 32'(stall_raw), 0);
        chk("wb_cleared_ready", 32'(issue_ready), 1);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("x0_raw", 32'(stall_raw), 0);
        chk("x0_waw", 32'(stall_waw), 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("x0_nopush", 32'(inflight), 1);
        drive(0, 0, 0, 0, 0, 1, 0);
        idle();
        chk("drain_empty", 32'(empty), 1);
        for (int r = 1; r <= 4; r++) drive(1, r, 0, 0, 0, 0, 0);
        drive(1, 10, 0, 0, 0, 0, 0);
        chk("full4", 32'(full), 1);
        chk("full4_ready", 32'(issue_ready), 0);
        drive(1, 10, 0, 0, 1, 0, 0);
        drive(1, 10, 0, 0, 0, 1, 0);
        chk("wb_full_refuse", 32'(issue_ready), 0);
        drive(1, 6, 0, 0, 0, 0, 0);
        chk("after_wb_full", 32'(full), 0);
        chk("after_wb_inflight", 32'(inflight), 3);
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("wrap_full", 32'(full), 1);
        repeat (3) drive(0, 0, 0, 0, 1, 1, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        idle();
        chk("wrap_empty", 32'(empty), 1);
        drive(1, 7, 0, 0, 0, 0, 0);
        drive(1, 8, 0, 0, 0, 0, 0);
        drive(1, 9, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("flush_ready", 32'(issue_ready), 0);
        drive(1, 12, 7, 8, 0, 0, 0);
        chk("flush_inflight", 32'(inflight), 1);
        chk("flush_keep7", 32'(stall_raw), 1);
        drive(1, 12, 8, 9, 0, 0, 0);
        chk("flush_drop89", 32'(stall_raw), 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        chk("proto_before", 32'(proto_err), 0);
        drive(0, 0, 0, 0, 1, 1, 0);
        chk("proto_set", 32'(proto_err), 1);
        chk("proto_state", 32'(inflight), 1);
        idle();
        chk("proto_sticky", 32'(proto_err), 1);
        rst = 1'b1;
        #1;
        chk("async_rst_empty", 32'(empty), 1);
        chk("async_rst_proto", 32'(proto_err), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(1, 3, 0, 0, 0, 0, 0);
        drive(1, 4, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 1);
        idle();
        chk("commit_flush", 32'(inflight), 2);
        drive(1, 5, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 1);
        idle();
        chk("wb_flush", 32'(inflight), 1);
        drive(0, 0, 0, 0, 0, 1, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        repeat (3) drive(1, 2, 1, 0, 0, 0, 0);
        drive(1, 2, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 300; i++)
            drive($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
        idle();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
